// File: rtl/writeback_buffer.sv
// -----------------------------------------------------------------------------
// writeback_buffer
//
// Purpose:
//   Receiving end of the cache eviction interface. Evicted dirty words are
//   queued in a small circular FIFO and drained to main memory one at a time
//   over a req/ack handshake. While a word sits in the queue, the cache's
//   miss-fill path can look it up here, so a miss never picks up stale RAM
//   contents for a word that has not reached memory yet.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   evict_valid  cache presents an evicted word this cycle
//   evict_addr   byte address of the evicted word
//   evict_data   evicted word
//   evict_ready  buffer can take an eviction (not full)
//   lookup_addr  miss address currently being filled from RAM
//   lookup_hit   lookup_addr matches a buffered word
//   lookup_data  buffered word for lookup_addr, 0 when there is no hit
//   mem_req      write request to main memory (registered)
//   mem_addr     address of the head entry
//   mem_wd       data of the head entry
//   mem_ack      memory accepted the current write
//   empty        no valid entries
//   full         DEPTH valid entries
//   overflow     sticky flag: an eviction arrived while full
// -----------------------------------------------------------------------------
module writeback_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evict_valid,
    input  logic [ADDR_WIDTH-1:0] evict_addr,
    input  logic [DATA_WIDTH-1:0] evict_data,
    output logic                  evict_ready,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_data,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic                  mem_ack,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Word-granular address compare: byte offset bits [1:0] never matter.
    function automatic logic word_match(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [ADDR_WIDTH-1:0] b);
        return (a[ADDR_WIDTH-1:2] == b[ADDR_WIDTH-1:2]);
    endfunction

    // Entry storage
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_coal_hit;
    logic [PTR_W-1:0]      w_coal_idx;
    logic                  w_do_append;
    logic                  w_do_coal;
    logic [CNT_W-1:0]      w_count_next;
    state_t                w_state_next;
    logic                  w_lk_hit;
    logic [DATA_WIDTH-1:0] w_lk_data;
    logic [PTR_W-1:0]      w_lk_idx;

    assign w_full = (r_count == DEPTH_CNT);
    // evict_ready depends only on the current count, so a pop in the same
    // cycle never lets a word in while full.
    assign w_push = evict_valid && !w_full;
    // mem_ack only has meaning while a request is outstanding.
    assign w_pop  = (r_state == ST_REQ) && mem_ack;

    // Find a queued entry the incoming word can merge into; the in-flight
    // head is excluded because memory may already be sampling its data.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = PTR_W'(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && word_match(r_addr[i], evict_addr) &&
                !((r_state == ST_REQ) && (PTR_W'(i) == r_head))) begin
                w_coal_hit = 1'b1;
                w_coal_idx = PTR_W'(i);
            end else begin
                w_coal_hit = w_coal_hit;
            end
        end
    end

    assign w_do_coal   = w_push && w_coal_hit;
    assign w_do_append = w_push && !w_coal_hit;

    // Next occupancy and drain FSM next state.
    always_comb begin
        w_count_next = r_count;
        w_state_next = r_state;
        case ({w_do_append, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
        // Request whenever something remains queued after this edge; this
        // covers IDLE->REQ on the first push and back-to-back writes in REQ.
        case (r_state)
            ST_IDLE: begin
                if (w_count_next != CNT_ZERO) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_count_next != CNT_ZERO) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Drain FSM state, registered request, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_count    <= CNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mem_req <= (w_state_next == ST_REQ);
            r_count   <= w_count_next;
            if (evict_valid && w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // FIFO pointers and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= PTR_W'(1'b0);
            r_tail  <= PTR_W'(1'b0);
            r_valid <= DEPTH'(1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= ADDR_WIDTH'(1'b0);
                r_data[i] <= DATA_WIDTH'(1'b0);
            end
        end else begin
            // Appending never targets the head being popped: appending needs
            // the buffer not full, and popping needs it not empty.
            if (w_do_append) begin
                r_addr[r_tail]  <= evict_addr;
                r_data[r_tail]  <= evict_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_ONE;
            end else if (w_do_coal) begin
                r_data[w_coal_idx] <= evict_data;
            end else begin
                r_tail <= r_tail;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_ONE;
            end else begin
                r_head <= r_head;
            end
        end
    end

    // Forwarding: walk from oldest to newest so the newest match wins.
    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_data = DATA_WIDTH'(1'b0);
        w_lk_idx  = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_lk_idx = r_head + PTR_W'(k);
            if (r_valid[w_lk_idx] && word_match(r_addr[w_lk_idx], lookup_addr)) begin
                w_lk_hit  = 1'b1;
                w_lk_data = r_data[w_lk_idx];
            end else begin
                w_lk_hit = w_lk_hit;
            end
        end
    end

    assign evict_ready = !w_full;
    assign full        = w_full;
    assign empty       = (r_count == CNT_ZERO);
    assign overflow    = r_overflow;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_addr[r_head];
    assign mem_wd      = r_data[r_head];
    assign lookup_hit  = w_lk_hit;
    assign lookup_data = w_lk_data;

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
Receiving end of the cache eviction interface: accepts evicted dirty words (valid/address/data) from the two-way cache and queues them in a small FIFO. Drains the queue to main memory over a req/ack handshake. Also forwards buffered data to the cache's miss-fill path, so a miss never reads stale RAM for a word still queued. Sits between the cache's eviction outputs and the data RAM write port.

Parameters:
DATA_WIDTH, 32, width of each buffered word
ADDR_WIDTH, 32, byte-address width of evicted words
DEPTH, 4, number of buffer entries (power of 2, >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
evict_valid  input  1  cache presents an evicted word this cycle (driven from the cache's eviction write-enable)
evict_addr  input  ADDR_WIDTH  byte address of evicted word
evict_data  input  DATA_WIDTH  evicted word
evict_ready  output  1  buffer can accept an eviction (= !full)
lookup_addr  input  ADDR_WIDTH  miss address being filled from RAM
lookup_hit  output  1  lookup_addr matches a buffered entry
lookup_data  output  DATA_WIDTH  buffered word for lookup_addr (0 when no hit)
mem_req  output  1  write request to main memory
mem_addr  output  ADDR_WIDTH  head entry address
mem_wd  output  DATA_WIDTH  head entry data
mem_ack  input  1  memory accepted the current write
empty  output  1  no valid entries
full  output  1  DEPTH valid entries
overflow  output  1  sticky: evict_valid seen while full

Behaviour:
- Reset (async, rst_n=0): pointers=0, count=0, all entry valid bits=0, FSM=IDLE, mem_req=0, overflow=0. Hence empty=1, full=0, evict_ready=1, lookup_hit=0, lookup_data=0. Assertion mid-handshake drops mem_req immediately; queued entries are discarded.
- Storage: circular FIFO; head/tail pointers of clog2(DEPTH) bits wrap modulo DEPTH; count has clog2(DEPTH)+1 bits.
- Address match uses word address only: bits [ADDR_WIDTH-1:2]; bits [1:0] are ignored everywhere.
- Accept: a push occurs when evict_valid && evict_ready at a rising edge.
  - Coalesce: if a valid entry other than an in-flight head (FSM=REQ) has a matching word address, overwrite that entry's data. No new entry, count unchanged.
  - Otherwise write the entry at tail, advance tail, count+1.
- evict_valid while full: word is not accepted and overflow sets (cleared only by reset). evict_ready is deasserted whenever full, even if a pop occurs in the same cycle.
- Drain FSM (states IDLE, REQ; mem_req is registered and is 1 exactly in REQ):
  - IDLE -> REQ on the edge where count>0 (including an entry pushed that same edge). First request is therefore visible one cycle after the first push.
  - REQ: mem_addr/mem_wd are driven combinationally from the head entry and are held stable until mem_ack.
  - REQ with mem_ack=1: pop head (clear valid, advance head, count-1). Stay in REQ if any entry remains after pop+push in that cycle; else go to IDLE. This gives back-to-back writes with no bubble.
  - mem_ack is ignored in IDLE.
- Push and pop in the same edge: count unchanged; both pointers advance.
- Forwarding (combinational): compare lookup_addr against all valid entries. If several match (in-flight head plus a newer entry), the newest entry wins. An entry being pushed this cycle is not visible until the next cycle. An entry popped this cycle remains visible during the ack cycle.
- empty = (count==0); full = (count==DEPTH).

Test Plan:
- Reset then single eviction: addr=0x100, data=0xDEADBEEF at T0 -> mem_req=1 at T1 with mem_addr=0x100, mem_wd=0xDEADBEEF; hold ack low 3 cycles (outputs stable); ack at T4 -> empty=1, mem_req=0 at T5.
- Fill to DEPTH=4 with ack held low (addrs 0x0,0x4,0x8,0xC) -> full=1, evict_ready=0; a 5th eviction (0x10) sets overflow=1 and is never written. Ack 4 times -> writes in order 0x0,0x4,0x8,0xC with mem_req continuous.
- Coalesce: push 0x20/0x1111, then 0x40/0x2222, then 0x40/0x3333 while head 0x20 is in flight -> count=2; memory receives 0x20=0x1111 then 0x40=0x3333 only.
- Forwarding: buffer 0x80=0xAAAA, lookup_addr=0x82 -> lookup_hit=1, lookup_data=0xAAAA. lookup_addr=0x84 -> lookup_hit=0, lookup_data=0.
- Simultaneous push/pop: count=1 in REQ, ack plus push of 0x200 on the same edge -> count stays 1, FSM stays REQ, next mem_addr=0x200.
- Reset mid-operation: 3 entries queued, mem_req=1, pulse rst_n low -> mem_req=0 immediately, empty=1, overflow=0, queued writes never issued.
